db25_gpio_bridge: RTL and testbench

- Pin-level bridge between the HostMot2 IOBits bus and the DE0-Nano 36-pin GPIO expansion header when the board is fitted with the dual DB25 adaptor.
- Maps 2 ports × 17 pins onto the header, registers all outputs, and synchronizes all inputs into the HostMot2 clock domain.
- Gates output drive with the HostMot2 enable, and drives one activity LED per port through a pulse stretcher.
- Sits directly downstream of the board parameter package, which supplies its widths, and between the hostmot2 core and the top-level pin buffers.

---
 rtl/db25_gpio_bridge_if.sv | 26 ++
 rtl/db25_gpio_bridge.sv | 100 ++++++++++
 tb/tb_db25_gpio_bridge.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/db25_gpio_bridge_if.sv
// Pin-level bundle between the HostMot2 IOBits bus and the DB25 GPIO header.
// No handshake: every signal is a level, sampled/driven on each rising clk; the bridge takes the slave modport.
interface db25_gpio_bridge_if #(
  parameter int IOWidth   = 34,
  parameter int GPIOWidth = 36,
  parameter int LEDCount  = 2
);
  logic [IOWidth-1:0]   iobits_out;
  logic [IOWidth-1:0]   iobits_oe;
  logic                 outputs_enable;
  logic [IOWidth-1:0]   iobits_in;
  logic [GPIOWidth-1:0] gpio_in;
  logic [GPIOWidth-1:0] gpio_out;
  logic [GPIOWidth-1:0] gpio_oe;
  logic [LEDCount-1:0]  led_out;

  modport slave (
    input  iobits_out, iobits_oe, outputs_enable, gpio_in,
    output iobits_in, gpio_out, gpio_oe, led_out
  );

  modport master (
    output iobits_out, iobits_oe, outputs_enable, gpio_in,
    input  iobits_in, gpio_out, gpio_oe, led_out
  );
endinterface

// File: rtl/db25_gpio_bridge.sv
// Maps 2 x 17 HostMot2 IOBits onto the 36-pin DE0-Nano header: registered outputs,
// synchronized inputs, enable-gated drive and a stretched activity LED per port.
module db25_gpio_bridge #(
  parameter int IOWidth       = 34,
  parameter int PortWidth     = 17,
  parameter int GPIOWidth     = 36,
  parameter int LEDCount      = 2,
  parameter int SyncStages    = 2,
  parameter int StretchCycles = 5000000
) (
  input logic               clk,
  input logic               reset_n,
  db25_gpio_bridge_if.slave bus
);

  localparam int Ports   = 2;
  localparam int PinSpan = PortWidth + 1;
  localparam int CntW    = $clog2(StretchCycles + 1);

  // Spare header pins (17, 35) are masked to 0 before the synchronizer so they never reach the core.
  function automatic logic [GPIOWidth-1:0] pin_mask();
    logic [GPIOWidth-1:0] m;
    m = '0;
    for (int p = 0; p < Ports; p++)
      for (int i = 0; i < PortWidth; i++)
        m[p*PinSpan+i] = 1'b1;
    return m;
  endfunction

  localparam logic [GPIOWidth-1:0] PinMask = pin_mask();

  logic [GPIOWidth-1:0] gpio_out_q, gpio_out_d;
  logic [GPIOWidth-1:0] gpio_oe_q, gpio_oe_d;
  logic [GPIOWidth-1:0] sync_q [SyncStages];
  logic [GPIOWidth-1:0] prev_q;
  logic [GPIOWidth-1:0] gpio_in_m;
  logic [GPIOWidth-1:0] in_chg, out_chg;
  logic [IOWidth-1:0]   iobits_in_c;
  logic [LEDCount-1:0]  event_c;
  logic [CntW-1:0]      cnt_q [LEDCount];
  logic [CntW-1:0]      cnt_d [LEDCount];
  logic [LEDCount-1:0]  led_q, led_d;

  assign gpio_in_m = bus.gpio_in & PinMask;

  always_comb begin
    gpio_out_d  = '0;
    gpio_oe_d   = '0;
    iobits_in_c = '0;
    for (int p = 0; p < Ports; p++) begin
      for (int i = 0; i < PortWidth; i++) begin
        gpio_out_d[p*PinSpan+i]    = bus.iobits_out[p*PortWidth+i];
        gpio_oe_d[p*PinSpan+i]     = bus.iobits_oe[p*PortWidth+i] & bus.outputs_enable;
        iobits_in_c[p*PortWidth+i] = sync_q[SyncStages-1][p*PinSpan+i];
      end
    end
  end

  // Output activity only counts bits that are actually driven after this edge.
  assign in_chg  = sync_q[SyncStages-1] ^ prev_q;
  assign out_chg = (gpio_out_d ^ gpio_out_q) & gpio_oe_d;

  always_comb begin
    event_c = '0;
    for (int p = 0; p < LEDCount; p++) begin
      cnt_d[p] = cnt_q[p];
      event_c[p] = (|in_chg[p*PinSpan +: PinSpan]) | (|out_chg[p*PinSpan +: PinSpan]);
      if (event_c[p])
        cnt_d[p] = CntW'(StretchCycles);
      else if (cnt_q[p] != '0)
        cnt_d[p] = cnt_q[p] - CntW'(1);
      led_d[p] = (cnt_d[p] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      prev_q     <= '0;
      led_q      <= '0;
      for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
      for (int p = 0; p < LEDCount; p++) cnt_q[p] <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_oe_q  <= gpio_oe_d;
      sync_q[0]  <= gpio_in_m;
      for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
      prev_q     <= sync_q[SyncStages-1];
      led_q      <= led_d;
      for (int p = 0; p < LEDCount; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign bus.gpio_out  = gpio_out_q;
  assign bus.gpio_oe   = gpio_oe_q;
  assign bus.iobits_in = iobits_in_c;
  assign bus.led_out   = led_q;

endmodule

// File: tb/tb_db25_gpio_bridge.sv
// Directed bench for db25_gpio_bridge with SyncStages=2, StretchCycles=8;
// stimulus pushes hand-computed expectations, a negedge monitor pops and compares them.
module tb_db25_gpio_bridge;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  db25_gpio_bridge_if #(.IOWidth(34), .GPIOWidth(36), .LEDCount(2)) bus ();

  db25_gpio_bridge #(
    .IOWidth(34), .PortWidth(17), .GPIOWidth(36), .LEDCount(2),
    .SyncStages(2), .StretchCycles(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  localparam int K_OUT = 0, K_OE = 1, K_IN = 2, K_LED = 3;

  typedef struct {
    int          cyc;
    int          kind;
    int          tag;
    logic [35:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mi;
  logic [35:0] act;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [35:0] actual(int kind);
    case (kind)
      K_OUT:   return bus.gpio_out;
      K_OE:    return bus.gpio_oe;
      K_IN:    return {2'b00, bus.iobits_in};
      default: return {34'b0, bus.led_out};
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      K_OUT:   return "gpio_out";
      K_OE:    return "gpio_oe";
      K_IN:    return "iobits_in";
      default: return "led_out";
    endcase
  endfunction

  // n = number of further rising edges before the value is checked (0 = before the next edge)
  task automatic expect_at(input int n, input int kind, input int tag, input logic [35:0] v);
    exp_t e;
    e.cyc  = edge_cnt + n;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    mi = 0;
    while (mi < exp_q.size()) begin
      if (exp_q[mi].cyc == edge_cnt) begin
        n_cmp++;
        act = actual(exp_q[mi].kind);
        if (act !== exp_q[mi].exp) begin
          n_bad++;
          $display("FAIL %s test%0d edge%0d: got %h expected %h",
                   kname(exp_q[mi].kind), exp_q[mi].tag, edge_cnt, act, exp_q[mi].exp);
        end
        exp_q.delete(mi);
      end else if (exp_q[mi].cyc < edge_cnt) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s test%0d: check for edge%0d was missed", kname(exp_q[mi].kind),
                 exp_q[mi].tag, exp_q[mi].cyc);
        exp_q.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  initial begin
    bus.iobits_out     = '0;
    bus.iobits_oe      = '0;
    bus.outputs_enable = 1'b0;
    bus.gpio_in        = '0;

    // 1: reset values
    tick(2);
    expect_at(0, K_OUT, 1, 36'h0);
    expect_at(0, K_OE,  1, 36'h0);
    expect_at(0, K_IN,  1, 36'h0);
    expect_at(0, K_LED, 1, 36'h0);
    tick();
    reset_n = 1'b1;

    // 2: pin map, 1-cycle output latency, spares never driven
    bus.iobits_oe      = '1;
    bus.outputs_enable = 1'b1;
    bus.iobits_out     = 34'h2_AAAA_AAAA;
    expect_at(0, K_OE,  2, 36'h0);
    expect_at(1, K_OUT, 2, 36'h5_5554_AAAA);
    expect_at(1, K_OE,  2, 36'h7_FFFD_FFFF);
    expect_at(1, K_LED, 2, 36'h3);
    expect_at(8, K_LED, 2, 36'h3);
    expect_at(9, K_LED, 2, 36'h0);
    tick(12);

    // 3: port 1 bit 2 input, two-edge sync latency, port-1 LED only
    bus.gpio_in[20] = 1'b1;
    expect_at(1,  K_IN,  3, 36'h0);
    expect_at(2,  K_IN,  3, 36'h8_0000);
    expect_at(2,  K_LED, 3, 36'h0);
    expect_at(3,  K_LED, 3, 36'h2);
    expect_at(10, K_LED, 3, 36'h2);
    expect_at(11, K_LED, 3, 36'h0);
    tick(14);

    // 4: port 0 event, retriggered 5 cycles later
    bus.gpio_in[3] = 1'b1;
    expect_at(2,  K_IN,  4, 36'h8_0008);
    expect_at(3,  K_LED, 4, 36'h1);
    expect_at(10, K_LED, 4, 36'h1);
    expect_at(11, K_LED, 4, 36'h1);
    expect_at(15, K_LED, 4, 36'h1);
    expect_at(16, K_LED, 4, 36'h0);
    tick(5);
    bus.gpio_in[3] = 1'b0;
    expect_at(2, K_IN, 4, 36'h8_0000);
    tick(14);

    // 5: outputs_enable low tri-states, data still tracks, no LED activity
    bus.outputs_enable = 1'b0;
    bus.iobits_out     = 34'h1_5555_5555;
    expect_at(1, K_OE,  5, 36'h0);
    expect_at(1, K_OUT, 5, 36'h2_AAA9_5555);
    expect_at(1, K_LED, 5, 36'h0);
    expect_at(2, K_LED, 5, 36'h0);
    tick(3);
    bus.iobits_out = 34'h2_AAAA_AAAA;
    expect_at(1, K_OUT, 5, 36'h5_5554_AAAA);
    expect_at(1, K_LED, 5, 36'h0);
    expect_at(2, K_LED, 5, 36'h0);
    tick(3);
    bus.outputs_enable = 1'b1;
    expect_at(0, K_OE,  5, 36'h0);
    expect_at(1, K_OE,  5, 36'h7_FFFD_FFFF);
    expect_at(1, K_LED, 5, 36'h0);
    tick(3);

    // 6: asynchronous reset mid-stretch, then release with pins high
    bus.gpio_in[0] = 1'b1;
    expect_at(3, K_LED, 6, 36'h1);
    tick(4);
    bus.outputs_enable = 1'b0;
    reset_n = 1'b0;
    expect_at(0, K_OUT, 6, 36'h0);
    expect_at(0, K_OE,  6, 36'h0);
    expect_at(0, K_IN,  6, 36'h0);
    expect_at(0, K_LED, 6, 36'h0);
    tick(2);
    reset_n = 1'b1;
    expect_at(1,  K_OUT, 6, 36'h5_5554_AAAA);
    expect_at(1,  K_OE,  6, 36'h0);
    expect_at(1,  K_IN,  6, 36'h0);
    expect_at(2,  K_IN,  6, 36'h8_0001);
    expect_at(2,  K_LED, 6, 36'h0);
    expect_at(3,  K_LED, 6, 36'h3);
    expect_at(10, K_LED, 6, 36'h3);
    expect_at(11, K_LED, 6, 36'h0);
    tick(13);

    // 7: spare header inputs are ignored
    for (int j = 0; j < 6; j++) begin
      bus.gpio_in[17] = ~bus.gpio_in[17];
      bus.gpio_in[35] = ~bus.gpio_in[35];
      expect_at(2, K_IN,  7, 36'h8_0001);
      expect_at(2, K_LED, 7, 36'h0);
      tick();
    end
    tick(4);

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) tick();
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d checks never reached", exp_q.size());
      n_cmp += exp_q.size();
      n_bad += exp_q.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
